seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for the board's 4-digit seven-segment display. It consumes the four BCD digits produced by the stopwatch stage and scans them onto shared segment lines, one digit per slot. The decimal point is fixed between seconds and centiseconds. An inter-digit blanking gap suppresses ghosting, and a lap-hold input freezes the shown value while the stopwatch keeps counting.

## Interface
- CLK_HZ, 25000000, clk4 frequency in Hz
- SLOT_HZ, 1000, digit-slot rate; full 4-digit frame = SLOT_HZ/4
- BLANK_CYCLES, 250, cycles at start of each slot with all anodes off; must be < CLK_HZ/SLOT_HZ
- COMMON_ANODE, 1, 1 = anodes/segments/dp active-low; 0 = active-high
- clk4  input  1  system clock
- reset  input  1  asynchronous, active-high
- enable  input  1  display on; 0 blanks display and clears hold
- digit_0  input  4  tens of seconds (leftmost, index 0)
- digit_1  input  4  seconds (index 1)
- digit_2  input  4  tenths (index 2)
- digit_3  input  4  hundredths (rightmost, index 3)
- lap  input  1  asynchronous button; each rising edge toggles hold
- an  output  4  digit anodes, bit i = digit index i
- seg  output  7  {g,f,e,d,c,b,a}
- dp  output  1  decimal point
- held  output  1  1 while display frozen

## Operation
- Slot counter counts 0 .. SLOT_LEN-1, where SLOT_LEN = CLK_HZ/SLOT_HZ; at terminal count it wraps to 0 and 2-bit index advances 0→1→2→3→0.
- Snapshot: 4×4-bit register. It loads all four digit_* inputs on the cycle the index wraps 3→0 with the slot counter at terminal count (frame boundary), unless held=1. Digits are never mixed across frames.
- Lap: 2-flop synchronizer, then rising-edge detector; each edge toggles held. Edge while held=1 releases; the snapshot reloads at the next frame boundary.
- Slot phases: counter < BLANK_CYCLES → an all inactive, seg all inactive, dp inactive. Otherwise an drives only bit [index] active; seg = decode(snapshot[index]); dp active only at index 1.
- Decode (active-high form, {g..a}): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Codes 10–15 show dash (40). COMMON_ANODE=1 inverts seg, an, and dp.
- enable=0: an/seg/dp inactive, held cleared, index and slot counter forced to 0, snapshot loads inputs every cycle. Lap edges are ignored while enable=0.
- Reset: an, seg, and dp inactive (COMMON_ANODE=1: an=4'hF, seg=7'h7F, dp=1); held=0; index=0; slot counter=0; snapshot=0; synchronizer flops=0.

## Timing
- an/seg/dp are registered. They reflect index/counter/snapshot state with 1-cycle latency.
- A lap input change reaches held 3 cycles after the edge at the pin: 2 sync flops plus the edge-detect register.
- The first active slot after reset or enable rise begins at counter=BLANK_CYCLES of index 0. Outputs show it one cycle later.
- The snapshot loaded at a frame boundary is first visible in index 0's active phase of the new frame.
- Simultaneous lap edge and frame boundary with held=0 → held becomes 1, and the load on that cycle is suppressed (hold wins).
- Reset mid-slot: outputs go inactive immediately (asynchronous) and the scan restarts at index 0.
- Width: slot counter = $clog2(SLOT_LEN) bits. No other arithmetic.

## Configuration
- LEADING_ZERO_BLANK_EN defined: when snapshot digit_0 == 0, index 0's slot keeps an[0] inactive for the whole slot. Timing and the other digits are unchanged.
- Not defined: digit 0 always shown, including "0".

## Test plan
Bench uses CLK_HZ=1000, SLOT_HZ=100 (SLOT_LEN=10), BLANK_CYCLES=2, COMMON_ANODE=1.
- Reset asserted mid-slot with enable=1 → same cycle an=F, seg=7F, dp=1, held=0; after release, an=E (index 0 active) appears at cycle 3.
- Digits 1,2,3,4, enable=1, run 2 frames → an cycles E,D,B,7; seg 79,24,30,19; dp=0 only while an=D; 2 inactive cycles at each slot start.
- Digits change 1234→5678 at an arbitrary mid-frame cycle → current frame finishes as 1234; the next frame shows 5678 with no mixed digits.
- Lap pulse, then digits change to 9999, then a second lap pulse → held=1 three cycles after the first edge and display stays 1234. After the second edge, held=0 and 9999 appears from the next frame.
- Digit value 12 applied on digit_2 → seg=3F (dash, inverted) during index 2; enable=0 → an=F and held=0 the next cycle.
- With LEADING_ZERO_BLANK_EN, digits 0,5,0,0 → an never equals E during the frame; digits 2–3 still show "0" (seg=40).

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//
// Purpose:
//   Time-multiplexed driver for a 4-digit seven-segment display. The four
//   BCD digits from the stopwatch are captured into a snapshot once per
//   frame. Each digit is then shown in its own slot on shared segment lines.
//   - Each slot begins with a short blanking gap that suppresses ghosting.
//   - The decimal point sits after digit index 1 (seconds).
//   - A lap button toggles a hold that freezes the snapshot while the
//     stopwatch keeps counting.
//
// Parameters:
//   CLK_HZ        clk4 frequency in Hz
//   SLOT_HZ       digit-slot rate (a full frame runs at SLOT_HZ/4)
//   BLANK_CYCLES  cycles at the start of each slot with all anodes off
//   COMMON_ANODE  1 = an/seg/dp active-low, 0 = active-high
//
// Ports:
//   clk4      in   1  system clock
//   reset     in   1  asynchronous, active-high
//   enable    in   1  display on. Low blanks the display and clears hold.
//   digit_0   in   4  tens of seconds (leftmost)
//   digit_1   in   4  seconds
//   digit_2   in   4  tenths
//   digit_3   in   4  hundredths (rightmost)
//   lap       in   1  asynchronous button. Each rising edge toggles hold.
//   an        out  4  digit anodes, bit i = digit index i
//   seg       out  7  segments {g,f,e,d,c,b,a}
//   dp        out  1  decimal point
//   held      out  1  high while the displayed value is frozen
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a snapshot digit_0 of zero keeps
//                          digit 0 dark for its whole slot.

module seg7_scan_driver #(
  parameter int CLK_HZ       = 25000000,
  parameter int SLOT_HZ      = 1000,
  parameter int BLANK_CYCLES = 250,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk4,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic       lap,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       held
);

  localparam int SLOT_LEN = CLK_HZ / SLOT_HZ;
  localparam int CNT_W    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  // Inactive output levels, used for reset and for blanking.
  localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = COMMON_ANODE;

  // Scan position.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  // Snapshot of the four digits. Element i corresponds to digit_i.
  logic [3:0][3:0]  snap_q, snap_d;

  // Lap synchronizer, edge-detect register and hold flag.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic held_q, held_d;

  // Registered display outputs.
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  // Internal combinational terms.
  logic       lap_edge;
  logic       slot_end;
  logic       frame_end;
  logic       show;
  logic [3:0] cur_digit;
  logic [3:0] an_hi;
  logic [6:0] seg_hi;
  logic       dp_hi;

  // Active-high segment pattern for one digit.
  // Codes 10..15 are not valid BCD and are shown as a dash.
  function automatic logic [6:0] decode_bcd(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'h3F;
      4'd1:    r = 7'h06;
      4'd2:    r = 7'h5B;
      4'd3:    r = 7'h4F;
      4'd4:    r = 7'h66;
      4'd5:    r = 7'h6D;
      4'd6:    r = 7'h7D;
      4'd7:    r = 7'h07;
      4'd8:    r = 7'h7F;
      4'd9:    r = 7'h6F;
      default: r = 7'h40;
    endcase
    return r;
  endfunction

  // Lap handling.
  // The button is synchronized through two flops. A third flop holds the
  // previous synchronized level, so a rising edge is the pulse where the
  // synchronized level is high and the previous level is low.
  always_comb begin
    sync1_d  = lap;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    lap_edge = sync2_q & ~sync3_q;
  end

  // Scan position, snapshot and hold state.
  //
  // While disabled, the scan is parked at index 0, count 0. The snapshot
  // tracks the inputs every cycle, so the first frame after enable rises
  // shows the current value.
  //
  // While enabled, the snapshot only loads at the frame boundary, so a
  // frame never mixes digits from two different values. When a lap edge
  // lands on the boundary while not held, the hold takes effect and the
  // load on that cycle is skipped.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    held_d    = held_q;
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 2'd3);

    if (!enable) begin
      cnt_d  = '0;
      idx_d  = 2'd0;
      held_d = 1'b0;
      snap_d = {digit_3, digit_2, digit_1, digit_0};
    end else begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      held_d = held_q ^ lap_edge;
      if (frame_end && !held_q && !lap_edge) begin
        snap_d = {digit_3, digit_2, digit_1, digit_0};
      end
    end
  end

  // Output generation.
  // Each slot starts with a blanking gap and then lights the current digit.
  // Patterns are built active-high and flipped once at the end for
  // common-anode boards. When show is low, the active-high patterns are all
  // zero, so the flip yields the inactive level.
  always_comb begin
    cur_digit = snap_q[idx_q];
    show      = enable && (cnt_q >= CNT_BLANK);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q == 2'd0) && (snap_q[0] == 4'd0)) begin
      show = 1'b0;
    end
`endif
    an_hi  = 4'h0;
    seg_hi = 7'h00;
    dp_hi  = 1'b0;
    if (show) begin
      an_hi  = 4'b0001 << idx_q;
      seg_hi = decode_bcd(cur_digit);
      dp_hi  = (idx_q == 2'd1);
    end
    an_d  = an_hi ^ {4{COMMON_ANODE}};
    seg_d = seg_hi ^ {7{COMMON_ANODE}};
    dp_d  = dp_hi ^ COMMON_ANODE;
  end

  // State registers.
  // On reset, every output goes to its inactive level immediately.
  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      held_q  <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      held_q  <= held_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign held = held_q;

endmodule
